// File: rtl/vcmd_stream_if.sv
// Host command byte stream and framebuffer pixel write port for vcmd_stream.
interface vcmd_stream_if #(
  parameter int CoordW   = 16,
  parameter int PixBytes = 1
);
  logic [7:0]            CmdIn;
  logic                  CmdValid;
  logic                  CmdReady;
  logic                  WrValid;
  logic                  WrReady;
  logic [CoordW-1:0]     WrX;
  logic [CoordW-1:0]     WrY;
  logic [8*PixBytes-1:0] WrData;

  modport master (
    output CmdIn, CmdValid, WrReady,
    input  CmdReady, WrValid, WrX, WrY, WrData
  );

  modport slave (
    input  CmdIn, CmdValid, WrReady,
    output CmdReady, WrValid, WrX, WrY, WrData
  );
endinterface

// File: rtl/vcmd_stream.sv
// Byte-serial VGA command decoder with cursor auto-increment and pixel writes.
// Optional stall timeout enabled by defining VCMD_TIMEOUT_EN.
module vcmd_stream #(
  parameter int CoordW        = 16,
  parameter int HRes          = 640,
  parameter int VRes          = 480,
  parameter int PixBytes      = 1,
  parameter int TimeoutCycles = 65535
) (
  input  logic Clk,
  input  logic Rst,
  vcmd_stream_if.slave bus,
  output logic BufSwap,
  output logic CmdErr,
  output logic Busy
);
  localparam int DW = 8 * PixBytes;
  localparam logic [CoordW-1:0] XMax = CoordW'(HRes - 1);
  localparam logic [CoordW-1:0] YMax = CoordW'(VRes - 1);
  localparam logic [1:0] LastB = 2'(PixBytes - 1);

  typedef enum logic [2:0] {
    StIdle, StXh, StXl, StYh,
    StYl, StCnt, StPix, StWait
  } state_t;

  state_t state, stateN;

  logic [CoordW-1:0] curX, curY;
  logic [CoordW-1:0] opCoord;
  logic              hInc;
  logic [7:0]        opHi;
  logic [8:0]        remCnt;
  logic [1:0]        byteIdx;
  logic [DW-1:0]     pixData;
  logic              cmdXfer;
  logic              wrXfer;
  logic              lastByte;
  logic              tmo;

  assign bus.CmdReady = !Rst && (state != StWait);
  assign bus.WrValid  = !Rst && (state == StWait);
  assign bus.WrX      = curX;
  assign bus.WrY      = curY;
  assign bus.WrData   = pixData;
  assign Busy         = !Rst && (state != StIdle);

  assign cmdXfer  = bus.CmdValid && bus.CmdReady;
  assign wrXfer   = bus.WrValid && bus.WrReady;
  assign lastByte = byteIdx == LastB;
  assign opCoord  = CoordW'({opHi, bus.CmdIn});

`ifdef VCMD_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] stallCnt;
  logic          stallSt;

  assign stallSt = state inside {StXh, StXl, StYh, StYl, StCnt, StPix};
  assign tmo = stallSt && !cmdXfer &&
               (stallCnt == TW'(TimeoutCycles - 1));

  always_ff @(posedge Clk) begin
    if (Rst || cmdXfer || !stallSt || tmo)
      stallCnt <= '0;
    else
      stallCnt <= stallCnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= StIdle;
    else     state <= stateN;
  end

  always_comb begin
    stateN = state;
    unique case (state)
      StIdle:
        if (cmdXfer) begin
          unique case (bus.CmdIn)
            8'h20:   stateN = StXh;
            8'h30:   stateN = StYh;
            8'h41:   stateN = StPix;
            8'h43:   stateN = StCnt;
            default: stateN = StIdle;
          endcase
        end
      StXh:  if (cmdXfer) stateN = StXl;
      StXl:  if (cmdXfer) stateN = StIdle;
      StYh:  if (cmdXfer) stateN = StYl;
      StYl:  if (cmdXfer) stateN = StIdle;
      StCnt: if (cmdXfer) stateN = StPix;
      StPix: if (cmdXfer && lastByte) stateN = StWait;
      StWait:
        if (wrXfer)
          stateN = (remCnt == 9'd1) ? StIdle : StPix;
      default: stateN = StIdle;
    endcase
    if (tmo) stateN = StIdle;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      curX    <= '0;
      curY    <= '0;
      hInc    <= 1'b1;
      opHi    <= '0;
      remCnt  <= '0;
      byteIdx <= '0;
      pixData <= '0;
      BufSwap <= 1'b0;
      CmdErr  <= 1'b0;
    end else begin
      BufSwap <= 1'b0;
      if (cmdXfer) begin
        unique case (state)
          StIdle: begin
            byteIdx <= '0;
            unique case (bus.CmdIn)
              8'h00, 8'h20, 8'h30, 8'h43: ;
              8'h01: BufSwap <= 1'b1;
              8'h02: CmdErr  <= 1'b0;
              8'h10: hInc    <= 1'b0;
              8'h11: hInc    <= 1'b1;
              8'h12: begin
                curX <= '0;
                curY <= '0;
              end
              8'h41:   remCnt <= 9'd1;
              default: CmdErr <= 1'b1;
            endcase
          end
          StXh, StYh: opHi <= bus.CmdIn;
          StXl:
            if (opCoord > XMax) CmdErr <= 1'b1;
            else                curX   <= opCoord;
          StYl:
            if (opCoord > YMax) CmdErr <= 1'b1;
            else                curY   <= opCoord;
          StCnt: begin
            remCnt  <= (bus.CmdIn == 8'h00) ? 9'd256
                                            : {1'b0, bus.CmdIn};
            byteIdx <= '0;
          end
          StPix: begin
            pixData <= DW'({pixData, bus.CmdIn});
            byteIdx <= lastByte ? 2'd0 : byteIdx + 2'd1;
          end
          default: ;
        endcase
      end
      if (wrXfer) begin
        remCnt <= remCnt - 9'd1;
        if (hInc) begin
          if (curX == XMax) begin
            curX <= '0;
            curY <= (curY == YMax) ? '0 : curY + 1'b1;
          end else begin
            curX <= curX + 1'b1;
          end
        end
      end
      if (tmo) CmdErr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vcmd_stream.sv
// Directed self-checking bench for vcmd_stream.
module tb_vcmd_stream;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic BufSwap, CmdErr, Busy;

  int checks = 0;
  int errs   = 0;
  int swapCnt = 0;

  typedef struct {
    int x;
    int y;
    int d;
  } wr_t;
  wr_t wq[$];

  vcmd_stream_if #(.CoordW(16), .PixBytes(1)) bus ();

`ifdef VCMD_TIMEOUT_EN
  vcmd_stream #(.TimeoutCycles(8)) dut (
`else
  vcmd_stream dut (
`endif
    .Clk     (Clk),
    .Rst     (Rst),
    .bus     (bus),
    .BufSwap (BufSwap),
    .CmdErr  (CmdErr),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!Rst && bus.WrValid && bus.WrReady)
      wq.push_back('{int'(bus.WrX), int'(bus.WrY), int'(bus.WrData)});
    if (BufSwap) swapCnt++;
  end

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    @(negedge Clk);
    bus.CmdIn = b;
    bus.CmdValid = 1'b1;
    while (!bus.CmdReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (bus.CmdReady !== 1'b1) begin
      errs++;
      $display("FAIL sendByte %02h: CmdReady never rose, got %b", b, bus.CmdReady);
    end
    @(posedge Clk);
    #1 bus.CmdValid = 1'b0;
  endtask

  task automatic test_reset();
    bus.CmdIn = 8'h00;
    bus.CmdValid = 1'b0;
    bus.WrReady = 1'b1;
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({bus.CmdReady, bus.WrValid, Busy, BufSwap, CmdErr} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.CmdReady, bus.WrValid, Busy, BufSwap, CmdErr});
    end
    checks++;
    if (bus.WrX !== 16'd0 || bus.WrY !== 16'd0 || bus.WrData !== 8'd0) begin
      errs++;
      $display("FAIL reset_bus: got %0d,%0d,%0h want 0,0,0",
               bus.WrX, bus.WrY, bus.WrData);
    end
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus.CmdReady !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready: got %b want 1", bus.CmdReady);
    end
  endtask

  task automatic test_setpos();
    sendByte(8'h20); sendByte(8'h01); sendByte(8'h3F);
    sendByte(8'h30); sendByte(8'h00); sendByte(8'h64);
    @(negedge Clk);
    checks++;
    if (bus.WrX !== 16'd319 || bus.WrY !== 16'd100) begin
      errs++;
      $display("FAIL setpos: got %0d,%0d want 319,100", bus.WrX, bus.WrY);
    end
    checks++;
    if (CmdErr !== 1'b0 || Busy !== 1'b0) begin
      errs++;
      $display("FAIL setpos_flags: err=%b busy=%b want 0,0", CmdErr, Busy);
    end
  endtask

  task automatic test_stream();
    wr_t exp[3] = '{'{638, 0, 'hA1}, '{639, 0, 'hA2}, '{0, 1, 'hA3}};
    sendByte(8'h20); sendByte(8'h02); sendByte(8'h7E);
    sendByte(8'h30); sendByte(8'h00); sendByte(8'h00);
    bus.WrReady = 1'b1;
    wq.delete();
    sendByte(8'h43); sendByte(8'h03);
    sendByte(8'hA1); sendByte(8'hA2); sendByte(8'hA3);
    repeat (3) @(negedge Clk);
    checks++;
    if (wq.size() !== 3) begin
      errs++;
      $display("FAIL stream_count: got %0d want 3", wq.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        errs++;
        if (i < wq.size())
          $display("FAIL stream_wr%0d: got %0d,%0d,%0h want %0d,%0d,%0h", i,
                   wq[i].x, wq[i].y, wq[i].d, exp[i].x, exp[i].y, exp[i].d);
        else
          $display("FAIL stream_wr%0d: got none want %0d,%0d,%0h", i,
                   exp[i].x, exp[i].y, exp[i].d);
      end
    end
    checks++;
    if (bus.WrX !== 16'd1 || bus.WrY !== 16'd1 || Busy !== 1'b0) begin
      errs++;
      $display("FAIL stream_end: got %0d,%0d busy=%b want 1,1,0",
               bus.WrX, bus.WrY, Busy);
    end
  endtask

  task automatic test_stall();
    int bad;
    wq.delete();
    sendByte(8'h10);
    bus.WrReady = 1'b0;
    for (int w = 0; w < 2; w++) begin
      sendByte(8'h41);
      sendByte(8'h55);
      bus.WrReady = 1'b0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge Clk);
        if (!bus.WrValid || bus.CmdReady || bus.WrX != 16'd1 ||
            bus.WrY != 16'd1 || bus.WrData != 8'h55) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errs++;
        $display("FAIL stall_hold%0d: %0d bad cycles, v=%b r=%b %0d,%0d,%0h want 1,0,1,1,55",
                 w, bad, bus.WrValid, bus.CmdReady, bus.WrX, bus.WrY, bus.WrData);
      end
      bus.WrReady = 1'b1;
    end
    repeat (2) @(negedge Clk);
    checks++;
    if (wq.size() !== 2) begin
      errs++;
      $display("FAIL stall_count: got %0d want 2", wq.size());
    end
    for (int i = 0; i < wq.size(); i++) begin
      checks++;
      if (wq[i].x !== 1 || wq[i].y !== 1 || wq[i].d !== 'h55) begin
        errs++;
        $display("FAIL stall_wr%0d: got %0d,%0d,%0h want 1,1,55",
                 i, wq[i].x, wq[i].y, wq[i].d);
      end
    end
    sendByte(8'h11);
  endtask

  task automatic test_err();
    sendByte(8'h20); sendByte(8'h03); sendByte(8'h00);
    @(negedge Clk);
    checks++;
    if (bus.WrX !== 16'd1 || CmdErr !== 1'b1) begin
      errs++;
      $display("FAIL err_range: got x=%0d err=%b want 1,1", bus.WrX, CmdErr);
    end
    sendByte(8'h02);
    @(negedge Clk);
    checks++;
    if (CmdErr !== 1'b0) begin
      errs++;
      $display("FAIL err_clear: got %b want 0", CmdErr);
    end
    sendByte(8'h7F);
    @(negedge Clk);
    checks++;
    if (CmdErr !== 1'b1 || Busy !== 1'b0) begin
      errs++;
      $display("FAIL err_unknown: err=%b busy=%b want 1,0", CmdErr, Busy);
    end
    sendByte(8'h02);
  endtask

  task automatic test_bufswap();
    int s0;
    s0 = swapCnt;
    sendByte(8'h01);
    @(negedge Clk);
    checks++;
    if (BufSwap !== 1'b1) begin
      errs++;
      $display("FAIL swap_pulse: got %b want 1", BufSwap);
    end
    @(negedge Clk);
    checks++;
    if (BufSwap !== 1'b0 || swapCnt !== s0 + 1) begin
      errs++;
      $display("FAIL swap_width: got %b cnt=%0d want 0,%0d", BufSwap, swapCnt - s0, 1);
    end
    wq.delete();
    s0 = swapCnt;
    sendByte(8'h43); sendByte(8'h02); sendByte(8'h01); sendByte(8'h01);
    repeat (3) @(negedge Clk);
    checks++;
    if (swapCnt !== s0 || wq.size() !== 2) begin
      errs++;
      $display("FAIL swap_in_stream: swaps=%0d writes=%0d want 0,2",
               swapCnt - s0, wq.size());
    end
    checks++;
    if (bus.WrX !== 16'd3 || bus.WrY !== 16'd1) begin
      errs++;
      $display("FAIL swap_cursor: got %0d,%0d want 3,1", bus.WrX, bus.WrY);
    end
  endtask

  task automatic test_rst_mid();
    sendByte(8'h43);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if ({bus.CmdReady, bus.WrValid, Busy, BufSwap, CmdErr} !== 5'b0 ||
        bus.WrX !== 16'd0 || bus.WrY !== 16'd0) begin
      errs++;
      $display("FAIL rst_cnt: ctrl=%b x=%0d y=%0d want 00000,0,0",
               {bus.CmdReady, bus.WrValid, Busy, BufSwap, CmdErr}, bus.WrX, bus.WrY);
    end
    Rst = 1'b0;
    bus.WrReady = 1'b0;
    sendByte(8'h41); sendByte(8'hAA);
    @(negedge Clk);
    checks++;
    if (bus.WrValid !== 1'b1) begin
      errs++;
      $display("FAIL rst_pend_setup: WrValid=%b want 1", bus.WrValid);
    end
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus.WrValid !== 1'b0 || Busy !== 1'b0 || bus.CmdReady !== 1'b1) begin
      errs++;
      $display("FAIL rst_pend: v=%b busy=%b rdy=%b want 0,0,1",
               bus.WrValid, Busy, bus.CmdReady);
    end
    bus.WrReady = 1'b1;
  endtask

`ifdef VCMD_TIMEOUT_EN
  task automatic test_timeout();
    int bad = 0;
    sendByte(8'h30); sendByte(8'h01);
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (Busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL tmo_early: idle in %0d of 8 stall cycles, want 0", bad);
    end
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || CmdErr !== 1'b1 || bus.WrY !== 16'd0) begin
      errs++;
      $display("FAIL tmo_fire: busy=%b err=%b y=%0d want 0,1,0",
               Busy, CmdErr, bus.WrY);
    end
    sendByte(8'h00);
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || bus.WrY !== 16'd0) begin
      errs++;
      $display("FAIL tmo_noop: busy=%b y=%0d want 0,0", Busy, bus.WrY);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_setpos();
    test_stream();
    test_stall();
    test_err();
    test_bufswap();
    test_rst_mid();
`ifdef VCMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/vcmd_stream.md
Name: vcmd_stream

Overview:
- Parametrised successor to the byte-serial VGA command decoder.
- Runs on the system clock and takes host command bytes over a valid/ready handshake.
- Decodes the position, mode, buffer-swap and pixel-write opcodes and tracks the draw cursor with auto-increment.
- Issues single-pixel write requests to the framebuffer write port, and emits buffer-swap pulses to the display scanner.

Parameters:
- CoordW, 16, width of the X/Y cursor registers and write address outputs.
- HRes, 640, horizontal resolution; X wrap point.
- VRes, 480, vertical resolution; Y wrap point.
- PixBytes, 1, bytes per pixel (1..3); WrData width is 8*PixBytes.
- TimeoutCycles, 65535, stall limit used only with VCMD_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- CmdIn  in  8  command/operand byte.
- CmdValid  in  1  CmdIn holds a byte.
- CmdReady  out  1  decoder accepts the byte this cycle.
- WrValid  out  1  pixel write request pending.
- WrReady  in  1  framebuffer accepts the request.
- WrX  out  CoordW  pixel column.
- WrY  out  CoordW  pixel row.
- WrData  out  8*PixBytes  pixel value; first received byte is the MSB.
- BufSwap  out  1  one-cycle swap pulse.
- CmdErr  out  1  sticky error flag.
- Busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset values:
  - State IDLE; X=0, Y=0; increment mode HInc.
  - All outputs 0, including CmdReady while Rst is high.
  - CmdReady is 1 in the first cycle after Rst falls.
- Handshake:
  - A byte transfers on a cycle with CmdValid&&CmdReady.
  - CmdReady=!WrValid, so no byte is accepted while a write is pending.
  - A write transfers on WrValid&&WrReady.
- Write request timing:
  - WrValid rises the cycle after the last pixel byte transfers.
  - WrX, WrY and WrData are held stable until WrValid&&WrReady.
- Throughput: with PixBytes=1 and WrReady tied high, one pixel every 2 cycles.
- States: IDLE, XH, XL, YH, YL, CNT, PIX, WAIT.
- Opcodes decoded in IDLE (all other opcodes listed here return to IDLE):
  - 0x00 Noop.
  - 0x01 BufSwap: BufSwap pulses high in the following cycle.
  - 0x02 ClrErr: CmdErr cleared.
  - 0x10 SetNoInc: cursor does not move after writes.
  - 0x11 SetHInc: cursor increments after writes.
  - 0x12 Set0: X=0, Y=0.
  - 0x20 SetX: goes to XH -> XL -> IDLE.
  - 0x30 SetY: goes to YH -> YL -> IDLE.
  - 0x41 Write1P: goes to PIX with a remaining count of 1.
  - 0x43 WriteNP: goes to CNT; the count byte N is loaded, N=0 meaning 256; then goes to PIX.
- SetX/SetY operands:
  - High byte first, then low byte; the value is truncated to CoordW.
  - Update commits on the low byte.
  - If the value is >= HRes (X) or >= VRes (Y): cursor unchanged and CmdErr set.
- PIX:
  - Shifts in PixBytes bytes, then goes to WAIT.
  - In WAIT, on write acceptance: decrement the count; next state is PIX if count>0, else IDLE.
- Cursor increment, applied on write acceptance in HInc mode only:
  - X+1.
  - If X==HRes-1: X=0 and Y+1.
  - If Y==VRes-1 as well: Y=0 (full-frame wrap).
- Unknown opcode: byte consumed, CmdErr set, state stays IDLE.
- Rst mid-command: partial operands discarded and any pending write dropped. WrValid is 0 from the cycle after Rst.
- BufSwap during a WriteNP stream: not decoded, because pixel bytes are never treated as opcodes.

Optional Feature:
- Macro: VCMD_TIMEOUT_EN.
- With the macro defined:
  - A stall counter increments each cycle in XH, XL, YH, YL, CNT or PIX when no byte transfers.
  - The counter clears on every transfer and on entry to IDLE.
  - When it reaches TimeoutCycles: return to IDLE, set CmdErr, discard partial operands and the remaining count; no write is issued.
- Without the macro: these states wait indefinitely; TimeoutCycles is unused and no counter logic is present.

Test Plan:
- Reset, then send 0x20,0x01,0x3F, then 0x30,0x00,0x64 -> cursor X=319, Y=100; CmdErr=0; Busy low after the last byte.
- PixBytes=1, cursor (638,0), WrReady=1; send 0x43,0x03,0xA1,0xA2,0xA3 -> three writes: (638,0,A1), (639,0,A2), (0,1,A3).
- Send 0x10, then 0x41,0x55 twice with WrReady held low for 5 cycles -> WrValid held, CmdReady=0, WrX/WrY/WrData stable; both writes land at the same address.
- Send 0x20,0x03,0x00 (X=768 >= 640) -> X unchanged, CmdErr=1; then send 0x02 -> CmdErr=0. Send 0x7F -> CmdErr=1.
- Send 0x01 -> BufSwap high for exactly 1 cycle. Rst asserted during CNT -> all outputs 0 and state IDLE the next cycle.
- Build with VCMD_TIMEOUT_EN, TimeoutCycles=8; send 0x30,0x01 then stall 8 cycles -> IDLE, CmdErr=1, Y unchanged; a next byte of 0x00 is decoded as Noop.
